fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 16-bit pipelined CPU.
- Sits directly upstream of the hazard unit and consumes its PC_WRITE, IF_ID_WRITE and IF_ID_FLASH outputs.
- Owns the PC, redirects it on branch/jump and on arithmetic overflow, and presents IF_ID_INSTR to decode.
- Contains a small BOOT/RUN/EXC state machine and a fetch counter.

Parameters:
PC_WIDTH, 16, PC and instruction-address width
INSTR_WIDTH, 16, instruction width
RESET_VECTOR, 16'h0000, PC value after reset
EXC_VECTOR, 16'h00F0, PC value loaded on overflow
NOP_INSTR, 16'h0000, bubble encoding loaded on flush
PC_STEP, 2, sequential PC increment (byte addressing)

Ports:
CLK  input  1  clock
RST  input  1  reset
PC_WRITE  input  1  hazard unit: 1 = PC may update, 0 = hold PC
IF_ID_WRITE  input  1  hazard unit: 1 = IF/ID may load, 0 = hold
IF_ID_FLASH  input  1  hazard unit: load bubble into IF/ID
BRANCH_JUMP_FLAG  input  1  taken branch/jump resolved this cycle
BRANCH_TARGET  input  PC_WIDTH  redirect address, valid with BRANCH_JUMP_FLAG
OVER_FLOW  input  1  ALU overflow exception from EX
IMEM_DATA  input  INSTR_WIDTH  instruction memory read data (combinational on IMEM_ADDR)
IMEM_ADDR  output  PC_WIDTH  current PC
IF_ID_INSTR  output  INSTR_WIDTH  registered instruction to decode
IF_ID_PC_NEXT  output  PC_WIDTH  registered PC+PC_STEP of that instruction
IF_ID_VALID  output  1  1 = IF_ID_INSTR is a real fetched instruction
EXC_ACTIVE  output  1  1 while in EXC state
FETCH_COUNT  output  16  saturating count of valid IF/ID loads

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RST. All state updates on the rising edge of CLK.
- Reset values:
  - PC = RESET_VECTOR.
  - IF_ID_INSTR = NOP_INSTR, IF_ID_PC_NEXT = 0, IF_ID_VALID = 0.
  - FETCH_COUNT = 0, EXC_ACTIVE = 0, state = BOOT.
  - RST has top priority in every state and mid-operation; it discards any pending redirect.
- IMEM_ADDR = PC combinationally. The fetch-to-IF/ID latency is 1 cycle.
- BOOT:
  - Inputs are ignored, PC holds, IF/ID holds the bubble.
  - Next state is RUN unconditionally (exactly one cycle).
- RUN, PC update, in priority order:
  1. OVER_FLOW: PC <= EXC_VECTOR, IF/ID <= bubble, state <= EXC.
  2. BRANCH_JUMP_FLAG: PC <= BRANCH_TARGET.
  3. PC_WRITE=0: PC holds.
  4. Otherwise PC <= PC + PC_STEP, wrapping modulo 2^PC_WIDTH with no flag.
- RUN, IF/ID update, in priority order:
  1. OVER_FLOW or IF_ID_FLASH: INSTR <= NOP_INSTR, VALID <= 0, PC_NEXT <= PC + PC_STEP.
  2. IF_ID_WRITE=0: hold all IF/ID fields.
  3. Otherwise INSTR <= IMEM_DATA, PC_NEXT <= PC + PC_STEP, VALID <= 1.
- Simultaneous events:
  - Flush together with IF_ID_WRITE=0: flush wins.
  - BRANCH_JUMP_FLAG together with PC_WRITE=0: branch wins, so a redirect is never lost to a stall.
  - OVER_FLOW together with BRANCH_JUMP_FLAG: overflow wins.
- EXC:
  - Lasts exactly one cycle with EXC_ACTIVE = 1.
  - PC holds EXC_VECTOR, IF/ID holds the bubble.
  - OVER_FLOW, BRANCH_JUMP_FLAG and the hazard inputs are ignored.
  - Next state is RUN; the first handler instruction is loaded into IF/ID on the following edge.
- FETCH_COUNT increments by 1 on every edge that loads VALID=1 from IMEM_DATA. It saturates at 16'hFFFF and clears only on RST.
- State encoding is 2 bits. The unused encoding returns to BOOT.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch_state_t (BOOT, RUN, EXC);
  - NOP_INSTR, RESET_VECTOR, EXC_VECTOR constants;
  - PC_WIDTH and INSTR_WIDTH.
- One natural sub-module, if_id_reg: the IF/ID register with the flush/hold/load priority. The PC logic, FSM and counter stay in fetch_stage.

Test Plan:
- Reset and BOOT: hold RST 2 cycles, then release with IMEM returning 16'h1234 at address 0.
  - One BOOT cycle shows VALID=0 and PC=0.
  - On the next edge IF_ID_INSTR=16'h1234, IF_ID_PC_NEXT=2, VALID=1, and PC reads 4 one edge after that.
- Stall: PC=8, PC_WRITE=0, IF_ID_WRITE=0 for 3 cycles.
  - PC stays 8, and IF/ID and FETCH_COUNT are unchanged.
  - After release, PC goes 8→10 and the instruction at address 8 is loaded.
- Branch: PC=10, BRANCH_JUMP_FLAG=1, BRANCH_TARGET=16'h0040, IF_ID_FLASH=1, PC_WRITE=0.
  - PC=16'h0040, IF/ID is a bubble with VALID=0, and the count is unchanged.
- Overflow: in RUN, OVER_FLOW=1 together with BRANCH_JUMP_FLAG=1 (target 16'h0080).
  - PC=16'h00F0 and EXC_ACTIVE=1 for 1 cycle with the bubble held.
  - The instruction at 16'h00F0 reaches IF/ID 2 edges after the overflow.
- Wrap and simultaneous controls:
  - PC=16'hFFFE sequential gives PC=0.
  - IF_ID_FLASH=1 with IF_ID_WRITE=0 gives a bubble (flush wins).
  - RST asserted in EXC gives the reset values next edge.
- Counter saturation: force FETCH_COUNT near 16'hFFFE and do 3 valid loads; the count stays at 16'hFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit pipelined CPU front end.
package cpu_pkg;

    localparam int unsigned PC_WIDTH    = 16;
    localparam int unsigned INSTR_WIDTH = 16;
    localparam int unsigned PC_STEP     = 2;

    localparam logic [15:0] RESET_VECTOR = 16'h0000;
    localparam logic [15:0] EXC_VECTOR   = 16'h00F0;
    localparam logic [15:0] NOP_INSTR    = 16'h0000;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        EXC  = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load.
module if_id_reg #(
    parameter int unsigned              PcWidth    = cpu_pkg::PC_WIDTH,
    parameter int unsigned              InstrWidth = cpu_pkg::INSTR_WIDTH,
    parameter logic [InstrWidth-1:0]    NopInstr   = InstrWidth'(cpu_pkg::NOP_INSTR)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  write_i,
    input  logic [InstrWidth-1:0] instr_i,
    input  logic [PcWidth-1:0]    pc_next_i,
    output logic [InstrWidth-1:0] instr_o,
    output logic [PcWidth-1:0]    pc_next_o,
    output logic                  valid_o,
    output logic                  load_o
);

    logic [InstrWidth-1:0] instr_q, instr_d;
    logic [PcWidth-1:0]    pc_next_q, pc_next_d;
    logic                  valid_q, valid_d;

    always_comb begin
        instr_d   = instr_q;
        pc_next_d = pc_next_q;
        valid_d   = valid_q;
        load_o    = 1'b0;
        if (flush_i) begin
            instr_d   = NopInstr;
            pc_next_d = pc_next_i;
            valid_d   = 1'b0;
        end else if (write_i) begin
            instr_d   = instr_i;
            pc_next_d = pc_next_i;
            valid_d   = 1'b1;
            load_o    = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q   <= NopInstr;
            pc_next_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pc_next_q <= pc_next_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_o   = instr_q;
    assign pc_next_o = pc_next_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, BOOT/RUN/EXC control, IF/ID register and fetch counter.
module fetch_stage #(
    parameter int unsigned             PC_WIDTH     = cpu_pkg::PC_WIDTH,
    parameter int unsigned             INSTR_WIDTH  = cpu_pkg::INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0]     RESET_VECTOR = PC_WIDTH'(cpu_pkg::RESET_VECTOR),
    parameter logic [PC_WIDTH-1:0]     EXC_VECTOR   = PC_WIDTH'(cpu_pkg::EXC_VECTOR),
    parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR    = INSTR_WIDTH'(cpu_pkg::NOP_INSTR),
    parameter int unsigned             PC_STEP      = cpu_pkg::PC_STEP
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   PC_WRITE,
    input  logic                   IF_ID_WRITE,
    input  logic                   IF_ID_FLASH,
    input  logic                   BRANCH_JUMP_FLAG,
    input  logic [PC_WIDTH-1:0]    BRANCH_TARGET,
    input  logic                   OVER_FLOW,
    input  logic [INSTR_WIDTH-1:0] IMEM_DATA,
    output logic [PC_WIDTH-1:0]    IMEM_ADDR,
    output logic [INSTR_WIDTH-1:0] IF_ID_INSTR,
    output logic [PC_WIDTH-1:0]    IF_ID_PC_NEXT,
    output logic                   IF_ID_VALID,
    output logic                   EXC_ACTIVE,
    output logic [15:0]            FETCH_COUNT
);

    import cpu_pkg::*;

    fetch_state_t          state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d, pc_plus;
    logic [15:0]           count_q, count_d;
    logic                  ifid_flush, ifid_write, ifid_load;

    assign pc_plus = pc_q + PC_WIDTH'(PC_STEP);

    // BOOT, EXC and the unused encoding leave the PC and IF/ID untouched.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_flush = 1'b0;
        ifid_write = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (OVER_FLOW) begin
                    pc_d       = EXC_VECTOR;
                    ifid_flush = 1'b1;
                    state_d    = EXC;
                end else begin
                    if (BRANCH_JUMP_FLAG) begin
                        pc_d = BRANCH_TARGET;
                    end else if (PC_WRITE) begin
                        pc_d = pc_plus;
                    end
                    ifid_flush = IF_ID_FLASH;
                    ifid_write = IF_ID_WRITE;
                end
            end
            EXC:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    assign count_d = (ifid_load && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    if_id_reg #(
        .PcWidth    (PC_WIDTH),
        .InstrWidth (INSTR_WIDTH),
        .NopInstr   (NOP_INSTR)
    ) u_if_id_reg (
        .clk_i     (CLK),
        .rst_i     (RST),
        .flush_i   (ifid_flush),
        .write_i   (ifid_write),
        .instr_i   (IMEM_DATA),
        .pc_next_i (pc_plus),
        .instr_o   (IF_ID_INSTR),
        .pc_next_o (IF_ID_PC_NEXT),
        .valid_o   (IF_ID_VALID),
        .load_o    (ifid_load)
    );

    assign IMEM_ADDR   = pc_q;
    assign EXC_ACTIVE  = (state_q == EXC);
    assign FETCH_COUNT = count_q;

endmodule
